communication_arbiter: RTL

COMMUNICATION_ARBITER -- requirements
Module: communication_arbiter

---
 rtl/communication_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/communication_arbiter.sv
// Round-robin link arbiter: grants one channel at a time, enforces a one-cycle
// gap between sessions, and can force-end a session after TIMEOUT active cycles.
module communication_arbiter #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 200,
  parameter int TMR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   comm_initiated,
  input  logic [N_CH-1:0]   comm_ended,
  output logic              is_communicating,
  output logic [N_CH-1:0]   grant,
  output logic [CH_W-1:0]  active_ch,
  output logic [N_CH-1:0]   pending,
  output logic              timeout_pulse,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_t            r_state;
  logic [N_CH-1:0]   r_grant;
  logic [CH_W-1:0]   r_active_ch;
  logic [N_CH-1:0]   r_pending;
  logic              r_is_comm;
  logic              r_timeout_pulse;
  logic [TMR_W-1:0]  r_timer;
  logic [CH_W-1:0]   r_rr_ptr;

  logic [N_CH-1:0]   w_owner;
  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_pend_next;
  logic [2*N_CH-1:0] w_rot;
  logic              w_found;
  int                w_off;
  logic [CH_W-1:0]   w_sel;
  logic [CH_W-1:0]   w_rr_next;
  logic              w_timeout_hit;
  logic              w_owner_end;

  assign w_owner = (r_state == ST_ACTIVE) ? (N_CH'(1) << r_active_ch) : '0;
  assign w_req   = r_pending | (comm_initiated & ~comm_ended);
  // A cancel from a non-owner beats a same-cycle initiate; the owner never queues.
  assign w_pend_next = (r_pending | (comm_initiated & ~w_owner)) & ~(comm_ended & ~w_owner);

  // Rotate the request vector so the search starts at rr_ptr.
  always_comb begin
    w_rot   = {w_req, w_req} >> r_rr_ptr;
    w_found = 1'b0;
    w_off   = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
  end

  assign w_sel         = CH_W'((int'(r_rr_ptr) + w_off) % N_CH);
  assign w_rr_next     = CH_W'((int'(w_sel) + 1) % N_CH);
  assign w_timeout_hit = (TIMEOUT > 0) && (r_timer == TMO_LAST);
  assign w_owner_end   = comm_ended[r_active_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_grant         <= '0;
      r_active_ch     <= '0;
      r_pending       <= '0;
      r_is_comm       <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_timer         <= '0;
      r_rr_ptr        <= '0;
    end else begin
      r_timeout_pulse <= 1'b0;
      r_pending       <= w_pend_next;
      case (r_state)
        ST_IDLE, ST_HOLDOFF: begin
          if (w_found) begin
            r_state     <= ST_ACTIVE;
            r_grant     <= N_CH'(1) << w_sel;
            r_active_ch <= w_sel;
            r_is_comm   <= 1'b1;
            r_timer     <= '0;
            r_rr_ptr    <= w_rr_next;
            r_pending   <= w_pend_next & ~(N_CH'(1) << w_sel);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          // Owner end takes priority over a coincident timeout.
          if (w_owner_end || w_timeout_hit) begin
            r_state         <= ST_HOLDOFF;
            r_grant         <= '0;
            r_is_comm       <= 1'b0;
            r_timeout_pulse <= !w_owner_end;
          end else if (r_timer != {TMR_W{1'b1}}) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= '0;
          r_is_comm <= 1'b0;
        end
      endcase
    end
  end

  assign is_communicating = r_is_comm;
  assign grant            = r_grant;
  assign active_ch        = r_active_ch;
  assign pending          = r_pending;
  assign timeout_pulse    = r_timeout_pulse;
  assign o_dbg_state      = r_state;

endmodule
